viterbi_ber_monitor: RTL and testbench
======================================

# viterbi_ber_monitor

Bit-error-rate monitor sitting directly downstream of the Viterbi decoder in the encoder -> channel -> decoder chain. It buffers the raw payload bits fed to the convolutional encoder, aligns them in order against the decoded bits, discards a configurable decoder warm-up prefix, and then counts compared bits, bit errors and the longest consecutive error run over a fixed measurement window. Results are held for readout until the next start.

## Interface
- DEPTH, 64: reference FIFO depth in bits; power of 2, >= 2.
- SKIP, 8: decoded bits discarded after start (traceback warm-up); 0 allowed.
- WINDOW, 256: compared bits per measurement; 1 .. 2^CW-1.
- CW, 16: width of all result counters.

- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_i  in  1  single-cycle pulse; clears and (re)starts a measurement.
- ref_valid_i  in  1  ref_bit_i valid this cycle (same qualifier as encoder input enable).
- ref_bit_i  in  1  payload bit entering the encoder.
- dec_valid_i  in  1  dec_bit_i valid this cycle.
- dec_bit_i  in  1  decoded bit from the Viterbi decoder.
- busy_o  out  1  high in SKIP or MEASURE.
- done_o  out  1  high in DONE.
- bit_ct_o  out  CW  compared bits in current/last window.
- err_ct_o  out  CW  mismatching bits.
- max_run_o  out  CW  longest run of consecutive mismatches.
- err_pulse_o  out  1  one-cycle pulse per mismatch.
- ovf_o  out  1  sticky: ref bit dropped on full FIFO.
- unf_o  out  1  sticky: decoded bit arrived with FIFO empty.

## Operation
- States: IDLE, SKIP, MEASURE, DONE. Reset -> IDLE.
- start_i in any state: clear FIFO, skip counter, run counter, all result outputs and sticky flags; next state SKIP (MEASURE if SKIP==0).
- FIFO active only in SKIP/MEASURE; ref_valid_i/dec_valid_i ignored in IDLE/DONE and in the start_i cycle.
- Push: ref_valid_i, occupancy < DEPTH. Push at occupancy == DEPTH with no same-cycle pop: bit dropped, ovf_o set. Full with simultaneous push and pop: both proceed, occupancy unchanged.
- Pop: dec_valid_i, occupancy > 0. Pop at occupancy 0: unf_o set, dec_bit dropped, nothing counted; a same-cycle push still proceeds (no bypass).
- SKIP: each successful pop increments skip counter, no comparison; the SKIP-th pop transitions to MEASURE.
- MEASURE, per successful pop: compare popped ref bit to dec_bit_i; bit_ct++; on mismatch err_ct++, run++, max_run = max(max_run, run+1), err_pulse_o; on match run = 0. Pop making bit_ct == WINDOW -> DONE.
- DONE: results frozen; FIFO contents irrelevant; only start_i or reset leaves.
- All counters saturate at 2^CW-1, never wrap. FIFO pointers log2(DEPTH) bits plus occupancy counter 0..DEPTH.

## Timing
- All outputs registered. Reset (async, immediate): state IDLE, FIFO empty, every output 0.
- start_i at edge n: busy_o = 1 and counters/flags = 0 after edge n.
- Comparison latency: pop at edge n -> bit_ct_o/err_ct_o/max_run_o/err_pulse_o updated after edge n.
- WINDOW-th compared pop at edge n -> after edge n: bit_ct_o = WINDOW, done_o = 1, busy_o = 0, same cycle.
- err_pulse_o high exactly one cycle per mismatch; back-to-back mismatches give back-to-back pulses.
- ovf_o/unf_o set after the offending edge, held until start_i or reset.
- Reset mid-measurement: abort, no partial results retained.

## Test plan
- Clean loopback: SKIP=0, WINDOW=256; dec stream = ref stream delayed 20 cycles -> done_o after 256th pop, bit_ct_o=256, err_ct_o=0, max_run_o=0, ovf_o=unf_o=0.
- Injected errors: flip decoded bits at compared indices 27,28 and 54,55 -> err_ct_o=4, max_run_o=2, exactly 4 err_pulse_o cycles.
- Warm-up: SKIP=8, first 8 decoded bits inverted -> err_ct_o=0, done_o after 264th pop with bit_ct_o=256.
- FIFO bounds: DEPTH=64, 70 ref pushes with no dec -> ovf_o=1, 64 bits retained; then 65 dec pops -> unf_o=1, bit_ct_o=64 (SKIP=0); simultaneous push+pop at full -> no ovf.
- Restart: start_i at bit_ct_o=100 with err_ct_o=3 -> all results 0 next cycle, FIFO empty, new window completes normally.
- Reset mid-MEASURE: rst low asynchronously -> all outputs 0 immediately, state IDLE; inputs ignored until start_i.

Source files
------------

// File: rtl/viterbi_ber_monitor_if.sv
// Bit streams in and BER results out of viterbi_ber_monitor.
// The master side drives the streams and reads the results.
interface viterbi_ber_monitor_if #(
    parameter int CW = 16
);
    logic          start_i;
    logic          ref_valid_i;
    logic          ref_bit_i;
    logic          dec_valid_i;
    logic          dec_bit_i;
    logic          busy_o;
    logic          done_o;
    logic [CW-1:0] bit_ct_o;
    logic [CW-1:0] err_ct_o;
    logic [CW-1:0] max_run_o;
    logic          err_pulse_o;
    logic          ovf_o;
    logic          unf_o;

    modport master (
        output start_i, ref_valid_i, ref_bit_i, dec_valid_i, dec_bit_i,
        input  busy_o, done_o, bit_ct_o, err_ct_o, max_run_o, err_pulse_o, ovf_o, unf_o
    );

    modport slave (
        input  start_i, ref_valid_i, ref_bit_i, dec_valid_i, dec_bit_i,
        output busy_o, done_o, bit_ct_o, err_ct_o, max_run_o, err_pulse_o, ovf_o, unf_o
    );
endinterface

// File: rtl/viterbi_ber_monitor.sv
// BER monitor for the decoder output. Reference payload bits are buffered in a FIFO and compared in order
// against decoded bits. The first SKIP decoded bits are discarded, and then WINDOW bits are measured.
module viterbi_ber_monitor #(
    parameter int DEPTH  = 64,
    parameter int SKIP   = 8,
    parameter int WINDOW = 256,
    parameter int CW     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    viterbi_ber_monitor_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = (SKIP > 1) ? $clog2(SKIP) : 1;
    localparam logic [CW-1:0] CT_MAX    = '1;
    localparam logic [CW-1:0] WIN_LAST  = CW'(WINDOW - 1);
    localparam logic [SW-1:0] SKIP_LAST = SW'((SKIP > 0) ? SKIP - 1 : 0);
    localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_SKIP, S_MEASURE, S_DONE} state_t;

    state_t        state, state_nxt;
    logic [DEPTH-1:0] mem;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   occ;
    logic [SW-1:0] skip_ct;
    logic [CW-1:0] bit_ct, err_ct, run_ct, max_run, run_inc;
    logic          err_pulse, ovf, unf;
    logic          active, pop, push, mismatch;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CT_MAX) ? v : v + CW'(1);
    endfunction

    // The start cycle belongs to the new measurement and moves no data.
    assign active   = ((state == S_SKIP) || (state == S_MEASURE)) && !bus.start_i;
    assign pop      = active && bus.dec_valid_i && (occ != '0);
    assign push     = active && bus.ref_valid_i && ((occ != FULL) || pop);
    assign mismatch = mem[rd_ptr] ^ bus.dec_bit_i;
    assign run_inc  = sat_inc(run_ct);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.start_i) begin
            state_nxt = (SKIP == 0) ? S_MEASURE : S_SKIP;
        end else begin
            case (state)
                S_SKIP:    if (pop && (skip_ct == SKIP_LAST)) state_nxt = S_MEASURE;
                S_MEASURE: if (pop && (bit_ct == WIN_LAST))   state_nxt = S_DONE;
                default:   ;
            endcase
        end
    end

    always_comb begin
        bus.busy_o = (state == S_SKIP) || (state == S_MEASURE);
        bus.done_o = (state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.ref_bit_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (bus.start_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      occ <= occ + (AW+1)'(1);
            else if (pop && !push) occ <= occ - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skip_ct   <= '0;
            bit_ct    <= '0;
            err_ct    <= '0;
            run_ct    <= '0;
            max_run   <= '0;
            err_pulse <= 1'b0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
        end else if (bus.start_i) begin
            skip_ct   <= '0;
            bit_ct    <= '0;
            err_ct    <= '0;
            run_ct    <= '0;
            max_run   <= '0;
            err_pulse <= 1'b0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            if (active && bus.ref_valid_i && (occ == FULL) && !pop) ovf <= 1'b1;
            if (active && bus.dec_valid_i && (occ == '0))          unf <= 1'b1;
            if (pop && (state == S_SKIP)) skip_ct <= skip_ct + SW'(1);
            if (pop && (state == S_MEASURE)) begin
                bit_ct <= sat_inc(bit_ct);
                if (mismatch) begin
                    err_ct    <= sat_inc(err_ct);
                    run_ct    <= run_inc;
                    err_pulse <= 1'b1;
                    if (run_inc > max_run) max_run <= run_inc;
                end else begin
                    run_ct <= '0;
                end
            end
        end
    end

    assign bus.bit_ct_o    = bit_ct;
    assign bus.err_ct_o    = err_ct;
    assign bus.max_run_o   = max_run;
    assign bus.err_pulse_o = err_pulse;
    assign bus.ovf_o       = ovf;
    assign bus.unf_o       = unf;
endmodule

// File: tb/tb_viterbi_ber_monitor.sv
// Scoreboard bench: two monitor configurations share stimulus. A queue-based model predicts every cycle,
// and a separate monitor pops and compares the predictions against the outputs.
module tb_viterbi_ber_monitor;
    localparam int NH = 16384;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic [31:0] bitc;
        logic [31:0] errc;
        logic [31:0] maxr;
        logic        pulse;
        logic        ovf;
        logic        unf;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rst_lvl = 1'b0;
    always #5 clk = ~clk;

    viterbi_ber_monitor_if #(.CW(16)) bus_a ();
    viterbi_ber_monitor_if #(.CW(5))  bus_b ();

    viterbi_ber_monitor #(.DEPTH(64), .SKIP(8), .WINDOW(256), .CW(16)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a));
    viterbi_ber_monitor #(.DEPTH(8), .SKIP(0), .WINDOW(20), .CW(5)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b));

    int p_depth [2] = '{64, 8};
    int p_skip  [2] = '{8, 0};
    int p_win   [2] = '{256, 20};
    int p_cw    [2] = '{16, 5};

    // Reference model: phase 0 idle, 1 warm-up, 2 measuring, 3 finished
    int ph [2], skipn [2], bitc [2], errc [2], run [2], maxr [2], head [2], tail [2];
    bit pulse [2], ovf [2], unf [2];
    bit hist [2][NH];

    obs_t exp_a [$];
    obs_t exp_b [$];
    int n_tests = 0;
    int n_fail  = 0;
    int pls_a   = 0;
    int cyc     = 0;

    function automatic int sat(int k, int v);
        int m = (1 << p_cw[k]) - 1;
        return (v > m) ? m : v;
    endfunction

    function automatic obs_t snap(int k);
        obs_t e;
        e.busy  = (ph[k] == 1) || (ph[k] == 2);
        e.done  = (ph[k] == 3);
        e.bitc  = 32'(sat(k, bitc[k]));
        e.errc  = 32'(sat(k, errc[k]));
        e.maxr  = 32'(sat(k, maxr[k]));
        e.pulse = pulse[k];
        e.ovf   = ovf[k];
        e.unf   = unf[k];
        return e;
    endfunction

    function automatic void clear_model(int k);
        head[k] = 0; tail[k] = 0; skipn[k] = 0; bitc[k] = 0; errc[k] = 0;
        run[k] = 0; maxr[k] = 0; pulse[k] = 0; ovf[k] = 0; unf[k] = 0;
    endfunction

    function automatic bit front(int k);
        return (tail[k] > head[k]) ? hist[k][head[k] % NH] : 1'b0;
    endfunction

    function automatic void step(int k, bit rstn, bit st, bit rv, bit rb, bit dv, bit db);
        int occ;
        bit pop, push, r;
        if (!rstn) begin
            clear_model(k);
            ph[k] = 0;
        end else if (st) begin
            clear_model(k);
            ph[k] = (p_skip[k] == 0) ? 2 : 1;
        end else begin
            pulse[k] = 0;
            if (ph[k] == 1 || ph[k] == 2) begin
                occ  = tail[k] - head[k];
                pop  = dv && (occ > 0);
                push = rv && ((occ < p_depth[k]) || pop);
                if (rv && !push) ovf[k] = 1;
                if (dv && occ == 0) unf[k] = 1;
                if (pop) begin
                    r = hist[k][head[k] % NH];
                    head[k]++;
                    if (ph[k] == 1) begin
                        skipn[k]++;
                        if (skipn[k] == p_skip[k]) ph[k] = 2;
                    end else begin
                        bitc[k]++;
                        if (r != db) begin
                            errc[k]++;
                            run[k]++;
                            if (run[k] > maxr[k]) maxr[k] = run[k];
                            pulse[k] = 1;
                        end else begin
                            run[k] = 0;
                        end
                        if (bitc[k] == p_win[k]) ph[k] = 3;
                    end
                end
                if (push) begin
                    hist[k][tail[k] % NH] = rb;
                    tail[k]++;
                end
            end
        end
    endfunction

    function automatic obs_t obs_a();
        obs_t o;
        o.busy = bus_a.busy_o; o.done = bus_a.done_o;
        o.bitc = 32'(bus_a.bit_ct_o); o.errc = 32'(bus_a.err_ct_o); o.maxr = 32'(bus_a.max_run_o);
        o.pulse = bus_a.err_pulse_o; o.ovf = bus_a.ovf_o; o.unf = bus_a.unf_o;
        return o;
    endfunction

    function automatic obs_t obs_b();
        obs_t o;
        o.busy = bus_b.busy_o; o.done = bus_b.done_o;
        o.bitc = 32'(bus_b.bit_ct_o); o.errc = 32'(bus_b.err_ct_o); o.maxr = 32'(bus_b.max_run_o);
        o.pulse = bus_b.err_pulse_o; o.ovf = bus_b.ovf_o; o.unf = bus_b.unf_o;
        return o;
    endfunction

    task automatic cmp(input string nm, input obs_t act, input obs_t e);
        n_tests++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL %s cyc %0d: got busy=%b done=%b bit=%0d err=%0d run=%0d pls=%b ovf=%b unf=%b, expected busy=%b done=%b bit=%0d err=%0d run=%0d pls=%b ovf=%b unf=%b",
                     nm, cyc, act.busy, act.done, act.bitc, act.errc, act.maxr, act.pulse, act.ovf, act.unf,
                     e.busy, e.done, e.bitc, e.errc, e.maxr, e.pulse, e.ovf, e.unf);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    // Monitor: one prediction per clock edge for each configuration
    initial begin
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus_a.err_pulse_o === 1'b1) pls_a++;
            if (exp_a.size() > 0) begin
                e = exp_a.pop_front();
                cmp("dut_a", obs_a(), e);
            end
            if (exp_b.size() > 0) begin
                e = exp_b.pop_front();
                cmp("dut_b", obs_b(), e);
            end
        end
    end

    task automatic tick(input bit st, input bit rv, input bit rb, input bit dv, input bit db);
        @(negedge clk);
        rst = rst_lvl;
        bus_a.start_i = st; bus_a.ref_valid_i = rv; bus_a.ref_bit_i = rb;
        bus_a.dec_valid_i = dv; bus_a.dec_bit_i = db;
        bus_b.start_i = st; bus_b.ref_valid_i = rv; bus_b.ref_bit_i = rb;
        bus_b.dec_valid_i = dv; bus_b.dec_bit_i = db;
        step(0, rst_lvl, st, rv, rb, dv, db);
        step(1, rst_lvl, st, rv, rb, dv, db);
        exp_a.push_back(snap(0));
        exp_b.push_back(snap(1));
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Sel 1 inverts warm-up bits and compared bits 27,28,54,55; sel 2 flips compared bits 10,40,70
    task automatic run_until(input int sel, input int stop_bitc);
        bit db;
        for (int c = 0; c < 3000; c++) begin
            if (ph[0] == 3 || ph[0] == 0) break;
            if (ph[0] == 2 && bitc[0] == stop_bitc) break;
            db = front(0);
            if (sel == 1 && ph[0] == 1) db = ~db;
            if (ph[0] == 2 && ((sel == 1 && (bitc[0] == 27 || bitc[0] == 28 || bitc[0] == 54 || bitc[0] == 55)) ||
                               (sel == 2 && (bitc[0] == 10 || bitc[0] == 40 || bitc[0] == 70))))
                db = ~db;
            tick(1'b0, 1'b1, 1'($urandom), c >= 20, db);
        end
    endtask

    initial begin
        bus_a.start_i = 0; bus_a.ref_valid_i = 0; bus_a.ref_bit_i = 0; bus_a.dec_valid_i = 0; bus_a.dec_bit_i = 0;
        bus_b.start_i = 0; bus_b.ref_valid_i = 0; bus_b.ref_bit_i = 0; bus_b.dec_valid_i = 0; bus_b.dec_bit_i = 0;
        ph[0] = 0; ph[1] = 0;
        clear_model(0);
        clear_model(1);

        repeat (3) tick(0, 0, 0, 0, 0);
        rst_lvl = 1'b1;
        repeat (5) tick(0, 1, 1'($urandom), 1, 1'($urandom));

        // Clean loopback
        tick(1, 0, 0, 0, 0);
        run_until(0, -1);
        settle();
        chk("loop done", 32'(bus_a.done_o), 1);
        chk("loop busy", 32'(bus_a.busy_o), 0);
        chk("loop bit_ct", 32'(bus_a.bit_ct_o), 256);
        chk("loop err_ct", 32'(bus_a.err_ct_o), 0);
        chk("loop max_run", 32'(bus_a.max_run_o), 0);
        chk("loop ovf", 32'(bus_a.ovf_o), 0);
        chk("loop unf", 32'(bus_a.unf_o), 0);

        // Warm-up inversion plus injected error pairs
        pls_a = 0;
        tick(1, 0, 0, 0, 0);
        run_until(1, -1);
        settle();
        chk("inj bit_ct", 32'(bus_a.bit_ct_o), 256);
        chk("inj err_ct", 32'(bus_a.err_ct_o), 4);
        chk("inj max_run", 32'(bus_a.max_run_o), 2);
        chk("inj pulses", 32'(pls_a), 4);

        // Results frozen in DONE
        repeat (10) tick(0, 1, 1'($urandom), 1, 1'($urandom));
        settle();
        chk("frozen err_ct", 32'(bus_a.err_ct_o), 4);
        chk("frozen done", 32'(bus_a.done_o), 1);

        // FIFO bounds
        tick(1, 0, 0, 0, 0);
        repeat (70) tick(0, 1, 1'($urandom), 0, 0);
        settle();
        chk("fill ovf", 32'(bus_a.ovf_o), 1);
        chk("fill unf", 32'(bus_a.unf_o), 0);
        repeat (65) tick(0, 0, 0, 1, 1'($urandom));
        settle();
        chk("drain unf", 32'(bus_a.unf_o), 1);
        chk("drain bit_ct", 32'(bus_a.bit_ct_o), 56);
        tick(1, 0, 0, 0, 0);
        repeat (64) tick(0, 1, 1'($urandom), 0, 0);
        repeat (10) tick(0, 1, 1'($urandom), 1, 1'($urandom));
        settle();
        chk("full push+pop ovf", 32'(bus_a.ovf_o), 0);

        // Restart mid-window
        tick(1, 0, 0, 0, 0);
        run_until(2, 100);
        settle();
        chk("pre-restart bit_ct", 32'(bus_a.bit_ct_o), 100);
        chk("pre-restart err_ct", 32'(bus_a.err_ct_o), 3);
        tick(1, 1, 1'($urandom), 1, 1'($urandom));
        settle();
        chk("restart bit_ct", 32'(bus_a.bit_ct_o), 0);
        chk("restart err_ct", 32'(bus_a.err_ct_o), 0);
        chk("restart busy", 32'(bus_a.busy_o), 1);
        run_until(0, -1);
        settle();
        chk("restart window", 32'(bus_a.bit_ct_o), 256);

        // Asynchronous reset mid-measurement
        tick(1, 0, 0, 0, 0);
        run_until(0, 50);
        rst_lvl = 1'b0;
        tick(0, 1, 1'($urandom), 1, 1'($urandom));
        #1;
        chk("arst a busy", 32'(bus_a.busy_o), 0);
        chk("arst a bit_ct", 32'(bus_a.bit_ct_o), 0);
        chk("arst a max_run", 32'(bus_a.max_run_o), 0);
        chk("arst b bit_ct", 32'(bus_b.bit_ct_o), 0);
        chk("arst b busy", 32'(bus_b.busy_o), 0);
        repeat (2) tick(0, 1, 1'($urandom), 1, 1'($urandom));
        rst_lvl = 1'b1;
        repeat (5) tick(0, 1, 1'($urandom), 1, 1'($urandom));

        // Randomized traffic with varying rates and occasional restarts
        tick(1, 0, 0, 0, 0);
        for (int blk = 0; blk < 6; blk++) begin
            int rp, dp;
            rp = $urandom_range(1, 4);
            dp = $urandom_range(1, 4);
            for (int c = 0; c < 500; c++) begin
                bit st, db;
                st = ($urandom_range(0, 249) == 0);
                db = front(0) ^ ($urandom_range(0, 11) == 0);
                tick(st, $urandom_range(0, 4) < rp, 1'($urandom), $urandom_range(0, 4) < dp, db);
            end
        end

        settle();
        chk("scoreboard drained", 32'(exp_a.size() + exp_b.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
